// File: rtl/ptp_pkg.sv
// Shared PTP timestamp definitions: entry width and the 8-bit queue status word layout.
package ptp_pkg;
  localparam int TS_WIDTH     = 128;
  localparam int STAT_W       = 8;
  localparam int STAT_OVF_BIT = 7;
  localparam int STAT_CNT_MSB = 6;

  typedef struct packed {
    logic                  ovf;
    logic [STAT_CNT_MSB:0] cnt;
  } ts_stat_t;

  function automatic logic [STAT_W-1:0] pack_stat(input logic ovf,
                                                  input logic [STAT_CNT_MSB:0] cnt);
    ts_stat_t s;
    s.ovf = ovf;
    s.cnt = cnt;
    return s;
  endfunction
endpackage

// File: rtl/ts_q_ram.sv
// Simple dual-port RAM: one write port, one registered read port that holds between reads.
module ts_q_ram #(
  parameter int AW = 4,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read-before-write: a same-address write this cycle returns the old entry.
  always_ff @(posedge clk) begin
    if (clr_i)     rd_q <= '0;
    else if (re_i) rd_q <= mem_q[raddr_i];
  end

  assign rdata_o = rd_q;
endmodule

// File: rtl/ptp_ts_queue.sv
// PTP timestamp FIFO between capture logic and the register block; drops the newest entry on overflow.
module ptp_ts_queue
  import ptp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                q_rst_in,
  input  logic                wr_en_in,
  input  logic [TS_WIDTH-1:0] wr_data_in,
  input  logic                rd_en_in,
  output logic [TS_WIDTH-1:0] rd_data_out,
  output logic [STAT_W-1:0]   stat_out,
  output logic                full_out,
  output logic                empty_out
);
  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  full_q, empty_q;
  logic                  flush, rd_acc, wr_acc;

  assign flush  = rst | q_rst_in;
  assign rd_acc = rd_en_in & ~empty_q;
  // A pop in the same cycle frees the slot, so a full queue still takes the write.
  assign wr_acc = wr_en_in & (~full_q | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
      if (wr_en_in && !wr_acc) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      full_q   <= (cnt_d == CNT_FULL);
      empty_q  <= (cnt_d == '0);
    end
  end

  ts_q_ram #(
    .AW (DEPTH_LOG2),
    .DW (TS_WIDTH)
  ) u_ram (
    .clk     (clk),
    .clr_i   (flush),
    .we_i    (wr_acc & ~flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data_in),
    .re_i    (rd_acc & ~flush),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data_out)
  );

  assign stat_out  = pack_stat(ovf_q, (STAT_CNT_MSB+1)'(cnt_q));
  assign full_out  = full_q;
  assign empty_out = empty_q;
endmodule
